// File: rtl/tlk2711_tx_cmd_gen.sv
// TLK2711 transmit command generator: splits a frame into DataMover read commands.
// Optional build macro TLK2711_TX_CMD_ALIGN_CHK_EN rejects starts on a base address not 8-byte aligned.
module tlk2711_tx_cmd_gen #(
    parameter int ADDR_W    = 32,
    parameter int BTT_W     = 23,
    parameter int MAX_BTT   = 4096,
    parameter int MAX_OUTST = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_soft_rst,
    input  logic                i_reg_wen,
    input  logic [11:0]         i_reg_waddr,
    input  logic [31:0]         i_reg_wdata,
    input  logic                i_reg_ren,
    input  logic [11:0]         i_reg_raddr,
    output logic [31:0]         o_reg_rdata,
    output logic                o_reg_rvalid,
    output logic [ADDR_W+39:0]  o_dma_cmd_data,
    output logic                o_dma_cmd_valid,
    input  logic                i_dma_cmd_ready,
    input  logic                i_dma_xfer_done,
    output logic                o_send_start,
    output logic [BTT_W-1:0]    o_frame_len,
    output logic                o_frame_done,
    output logic                o_busy
);
    // state | meaning
    // IDLE  | waiting for an accepted start
    // ISSUE | presenting a command, held until accepted
    // WAIT  | outstanding limit reached, or all issued and awaiting completions
    // DRAIN | aborted, waiting for in-flight commands to complete
    // DONE  | one-cycle frame completion
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_DONE} state_t;

    localparam logic [BTT_W-1:0]  LP_MAX_BTT   = BTT_W'(MAX_BTT);
    localparam logic [3:0]        LP_MAX_OUTST = 4'(MAX_OUTST);
    localparam logic [ADDR_W-1:0] LP_ADDR_STEP = ADDR_W'(MAX_BTT);

    state_t              r_state, w_state_nxt;
    logic [BTT_W-1:0]    r_len, r_remain, r_frame_len, w_btt, w_remain_nxt;
    logic [31:0]         r_addr_lo, r_addr_hi, r_rdata, w_rdata;
    logic [ADDR_W-1:0]   r_cmd_addr, w_base;
    logic [3:0]          r_tag, r_outst, w_outst_nxt;
    logic [15:0]         r_frame_cnt;
    logic [ADDR_W+39:0]  w_cmd;
    logic r_err_len, r_aborted, r_abort_req, r_send_start, r_rvalid;
    logic w_rst, w_wr_ctrl, w_start, w_abort, w_abort_any, w_start_req, w_start_ok;
    logic w_align_bad, w_err_align, w_xfer, w_done;

    assign w_rst        = i_rst | i_soft_rst;
    assign w_wr_ctrl    = i_reg_wen && (i_reg_waddr == 12'h004);
    assign w_start      = w_wr_ctrl & i_reg_wdata[0];
    assign w_abort      = w_wr_ctrl & i_reg_wdata[1];
    assign w_abort_any  = w_abort | r_abort_req;
    assign w_base       = ADDR_W'({r_addr_hi, r_addr_lo});
    assign w_start_req  = (r_state == S_IDLE) && w_start;
    assign w_start_ok   = w_start_req && (r_len != '0) && !w_align_bad;
    assign w_xfer       = o_dma_cmd_valid & i_dma_cmd_ready;
    assign w_done       = i_dma_xfer_done && (r_outst != 4'd0);
    assign w_remain_nxt = r_remain - w_btt;

`ifdef TLK2711_TX_CMD_ALIGN_CHK_EN
    logic r_err_align;
    assign w_align_bad = (w_base[2:0] != 3'b000);
    assign w_err_align = r_err_align;
    always_ff @(posedge i_clk) begin
        if (w_rst)
            r_err_align <= 1'b0;
        else if (w_start_req && (r_len != '0))
            r_err_align <= w_align_bad;
    end
`else
    assign w_align_bad = 1'b0;
    assign w_err_align = 1'b0;
`endif

    // A simultaneous transfer and completion leave the count unchanged.
    always_comb begin
        w_outst_nxt = r_outst;
        if (w_xfer && !w_done)
            w_outst_nxt = r_outst + 4'd1;
        else if (!w_xfer && w_done)
            w_outst_nxt = r_outst - 4'd1;
    end

    always_comb begin
        w_btt = (r_remain > LP_MAX_BTT) ? LP_MAX_BTT : r_remain;
        w_cmd = '0;
        if (o_dma_cmd_valid) begin
            w_cmd[BTT_W-1:0]           = w_btt;
            w_cmd[23]                  = 1'b1;
            w_cmd[30]                  = 1'b1;
            w_cmd[ADDR_W+31:32]        = r_cmd_addr;
            w_cmd[ADDR_W+35:ADDR_W+32] = r_tag;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (w_xfer) begin
                    if (w_abort_any)
                        w_state_nxt = S_DRAIN;
                    else if ((w_remain_nxt != '0) && (w_outst_nxt < LP_MAX_OUTST))
                        w_state_nxt = S_ISSUE;
                    else
                        w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_abort_any)
                    w_state_nxt = S_DRAIN;
                else if ((r_remain == '0) && (w_outst_nxt == 4'd0))
                    w_state_nxt = S_DONE;
                else if ((r_remain != '0) && (w_outst_nxt < LP_MAX_OUTST))
                    w_state_nxt = S_ISSUE;
            end
            S_DRAIN: if (w_outst_nxt == 4'd0) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_dma_cmd_valid = (r_state == S_ISSUE);
        o_busy          = (r_state != S_IDLE);
        o_frame_done    = (r_state == S_DONE);
    end

    always_comb begin
        w_rdata = '0;
        case (i_reg_raddr)
            12'h008: w_rdata = 32'(r_len);
            12'h00C: w_rdata = r_addr_lo;
            12'h010: w_rdata = r_addr_hi;
            12'h014: w_rdata = {r_frame_cnt, 12'd0, r_aborted, w_err_align, r_err_len, o_busy};
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_rst) begin
            r_len        <= '0;
            r_addr_lo    <= '0;
            r_addr_hi    <= '0;
            r_remain     <= '0;
            r_frame_len  <= '0;
            r_cmd_addr   <= '0;
            r_tag        <= '0;
            r_outst      <= '0;
            r_frame_cnt  <= '0;
            r_err_len    <= 1'b0;
            r_aborted    <= 1'b0;
            r_abort_req  <= 1'b0;
            r_send_start <= 1'b0;
            r_rvalid     <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_send_start <= w_start_ok;
            r_outst      <= w_outst_nxt;
            r_rvalid     <= i_reg_ren;
            r_rdata      <= i_reg_ren ? w_rdata : '0;
            if (i_reg_wen) begin
                case (i_reg_waddr)
                    12'h008: r_len     <= i_reg_wdata[BTT_W-1:0];
                    12'h00C: r_addr_lo <= i_reg_wdata;
                    12'h010: r_addr_hi <= i_reg_wdata;
                    default: ;
                endcase
            end
            if (w_start_req && (r_len == '0))
                r_err_len <= 1'b1;
            if (w_start_ok) begin
                r_err_len   <= 1'b0;
                r_aborted   <= 1'b0;
                r_abort_req <= 1'b0;
                r_cmd_addr  <= w_base;
                r_remain    <= r_len;
                r_frame_len <= r_len;
                r_tag       <= '0;
            end
            if (w_xfer) begin
                r_cmd_addr <= r_cmd_addr + LP_ADDR_STEP;
                r_remain   <= w_remain_nxt;
                r_tag      <= r_tag + 4'd1;
            end
            // An abort seen while a command is presented waits for its acceptance.
            if (w_abort && ((r_state == S_ISSUE) || (r_state == S_WAIT)))
                r_abort_req <= 1'b1;
            if ((r_state == S_DRAIN) && (w_state_nxt == S_DONE))
                r_aborted <= 1'b1;
            if (r_state == S_DONE)
                r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign o_dma_cmd_data = w_cmd;
    assign o_send_start   = r_send_start;
    assign o_frame_len    = r_frame_len;
    assign o_reg_rdata    = r_rdata;
    assign o_reg_rvalid   = r_rvalid;
endmodule

// File: tb/tb_tlk2711_tx_cmd_gen.sv
// Directed bench for tlk2711_tx_cmd_gen (MAX_OUTST=2): register table, frame table, stall/abort/reset sequences.
module tb_tlk2711_tx_cmd_gen;
    localparam int ADDR_W    = 32;
    localparam int BTT_W     = 23;
    localparam int MAX_BTT   = 4096;
    localparam int MAX_OUTST = 2;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1, i_soft_rst = 1'b0;
    logic        i_reg_wen = 1'b0, i_reg_ren = 1'b0;
    logic [11:0] i_reg_waddr = '0, i_reg_raddr = '0;
    logic [31:0] i_reg_wdata = '0;
    logic [31:0] o_reg_rdata;
    logic        o_reg_rvalid;
    logic [71:0] o_dma_cmd_data;
    logic        o_dma_cmd_valid;
    logic        i_dma_cmd_ready = 1'b0, i_dma_xfer_done = 1'b0;
    logic        o_send_start, o_frame_done, o_busy;
    logic [22:0] o_frame_len;

    tlk2711_tx_cmd_gen #(.ADDR_W(ADDR_W), .BTT_W(BTT_W), .MAX_BTT(MAX_BTT), .MAX_OUTST(MAX_OUTST)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_soft_rst(i_soft_rst),
        .i_reg_wen(i_reg_wen), .i_reg_waddr(i_reg_waddr), .i_reg_wdata(i_reg_wdata),
        .i_reg_ren(i_reg_ren), .i_reg_raddr(i_reg_raddr),
        .o_reg_rdata(o_reg_rdata), .o_reg_rvalid(o_reg_rvalid),
        .o_dma_cmd_data(o_dma_cmd_data), .o_dma_cmd_valid(o_dma_cmd_valid),
        .i_dma_cmd_ready(i_dma_cmd_ready), .i_dma_xfer_done(i_dma_xfer_done),
        .o_send_start(o_send_start), .o_frame_len(o_frame_len),
        .o_frame_done(o_frame_done), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } reg_vec_t;

    typedef struct {
        logic [22:0] len;
        logic [31:0] base;
        int          n;
        logic [22:0] last;
    } frame_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_cmd(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] exp_cmd(input logic [31:0] addr, input logic [22:0] btt, input logic [3:0] tag);
        logic [71:0] c;
        c        = '0;
        c[22:0]  = btt;
        c[23]    = 1'b1;
        c[30]    = 1'b1;
        c[63:32] = addr;
        c[67:64] = tag;
        return c;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic reg_write(input logic [11:0] a, input logic [31:0] d);
        i_reg_wen = 1'b1; i_reg_waddr = a; i_reg_wdata = d;
        tick();
        i_reg_wen = 1'b0;
    endtask

    task automatic reg_read(input logic [11:0] a, output logic [31:0] d);
        i_reg_ren = 1'b1; i_reg_raddr = a;
        tick();
        chk("rvalid", 32'(o_reg_rvalid), 32'd1);
        d = o_reg_rdata;
        i_reg_ren = 1'b0;
    endtask

    task automatic pulse_done();
        i_dma_xfer_done = 1'b1;
        tick();
        i_dma_xfer_done = 1'b0;
    endtask

    task automatic watch(input int ncyc, output int ncmd, output int nfd);
        ncmd = 0; nfd = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (o_dma_cmd_valid && i_dma_cmd_ready) ncmd++;
            if (o_frame_done) nfd++;
            tick();
        end
    endtask

    task automatic run_frame(input string nm, input logic [22:0] len, input logic [31:0] base,
                             input int exp_n, input logic [22:0] last_btt);
        int k = 0, pend = 0, fd = 0, cyc = 0;
        logic [71:0] e;
        reg_write(12'h008, 32'(len));
        reg_write(12'h00C, base);
        i_dma_cmd_ready = 1'b1;
        reg_write(12'h004, 32'h1);
        chk({nm, " send_start"}, 32'(o_send_start), 32'd1);
        while (fd == 0 && cyc < 300) begin
            if (o_dma_cmd_valid) begin
                e = exp_cmd(base + 32'(k) * 32'(MAX_BTT), (k == exp_n - 1) ? last_btt : 23'(MAX_BTT), 4'(k));
                chk_cmd({nm, " cmd"}, o_dma_cmd_data, e);
                k++;
            end
            if (o_frame_done) fd = 1;
            i_dma_xfer_done = (pend > 0);
            if (pend > 0) pend--;
            if (o_dma_cmd_valid) pend++;
            tick();
            cyc++;
        end
        i_dma_xfer_done = 1'b0;
        chk({nm, " n_cmds"}, 32'(k), 32'(exp_n));
        chk({nm, " frame_done"}, 32'(fd), 32'd1);
        chk({nm, " busy_after"}, 32'(o_busy), 32'd0);
        chk({nm, " frame_len"}, 32'(o_frame_len), 32'(len));
    endtask

    reg_vec_t    rv[12];
    frame_vec_t  fv[6];
    logic [31:0] rd;
    int          nc, nfd, frames, n_frames;

    initial begin
        rv[0]  = '{1'b0, 12'h014, 32'h0,        32'h0};
        rv[1]  = '{1'b1, 12'h008, 32'd820,      32'h0};
        rv[2]  = '{1'b0, 12'h008, 32'h0,        32'd820};
        rv[3]  = '{1'b1, 12'h00C, 32'h1000_0000, 32'h0};
        rv[4]  = '{1'b0, 12'h00C, 32'h0,        32'h1000_0000};
        rv[5]  = '{1'b1, 12'h010, 32'h0000_00AB, 32'h0};
        rv[6]  = '{1'b0, 12'h010, 32'h0,        32'h0000_00AB};
        rv[7]  = '{1'b0, 12'h004, 32'h0,        32'h0};
        rv[8]  = '{1'b0, 12'h020, 32'h0,        32'h0};
        rv[9]  = '{1'b0, 12'hFFC, 32'h0,        32'h0};
        rv[10] = '{1'b1, 12'h008, 32'hFFFF_FFFF, 32'h0};
        rv[11] = '{1'b0, 12'h008, 32'h0,        32'h007F_FFFF};

        fv[0] = '{23'd820,   32'h1000_0000, 1, 23'd820};
        fv[1] = '{23'd10000, 32'h1000_0000, 3, 23'd1808};
        fv[2] = '{23'd4096,  32'h2000_0000, 1, 23'd4096};
        fv[3] = '{23'd4097,  32'h2000_0000, 2, 23'd1};
        fv[4] = '{23'd1,     32'h3000_0000, 1, 23'd1};
        fv[5] = '{23'd8192,  32'h1000_0004, 2, 23'd4096};
`ifdef TLK2711_TX_CMD_ALIGN_CHK_EN
        n_frames = 5;
`else
        n_frames = 6;
`endif

        // reset
        repeat (3) tick();
        i_rst = 1'b0;
        chk("rst valid", 32'(o_dma_cmd_valid), 32'd0);
        chk("rst busy", 32'(o_busy), 32'd0);
        chk("rst send_start", 32'(o_send_start), 32'd0);
        chk("rst frame_done", 32'(o_frame_done), 32'd0);
        chk("rst rvalid", 32'(o_reg_rvalid), 32'd0);
        chk("rst frame_len", 32'(o_frame_len), 32'd0);
        chk_cmd("rst cmd_data", o_dma_cmd_data, 72'd0);

        // register table
        for (int i = 0; i < 12; i++) begin
            if (rv[i].wr) begin
                reg_write(rv[i].addr, rv[i].data);
            end else begin
                reg_read(rv[i].addr, rd);
                chk($sformatf("reg[%0d] rdata", i), rd, rv[i].exp);
            end
        end
        tick();
        chk("rvalid drop", 32'(o_reg_rvalid), 32'd0);
        reg_write(12'h010, 32'h0);

        // zero-length start
        reg_write(12'h008, 32'd0);
        reg_write(12'h00C, 32'h1000_0000);
        i_dma_cmd_ready = 1'b1;
        reg_write(12'h004, 32'h1);
        chk("len0 send_start", 32'(o_send_start), 32'd0);
        chk("len0 busy", 32'(o_busy), 32'd0);
        watch(5, nc, nfd);
        chk("len0 no cmd", 32'(nc), 32'd0);
        reg_read(12'h014, rd);
        chk("len0 status", rd, 32'h0000_0002);

        // frame table
        frames = 0;
        for (int i = 0; i < n_frames; i++) begin
            run_frame($sformatf("frame%0d", i), fv[i].len, fv[i].base, fv[i].n, fv[i].last);
            frames++;
        end
        reg_read(12'h014, rd);
        chk("status after frames", rd, {16'(frames), 16'h0000});

`ifdef TLK2711_TX_CMD_ALIGN_CHK_EN
        reg_write(12'h008, 32'd64);
        reg_write(12'h00C, 32'h1000_0004);
        reg_write(12'h004, 32'h1);
        chk("align send_start", 32'(o_send_start), 32'd0);
        chk("align busy", 32'(o_busy), 32'd0);
        watch(3, nc, nfd);
        chk("align no cmd", 32'(nc), 32'd0);
        reg_read(12'h014, rd);
        chk("align status", rd, {16'(frames), 16'h0004});
`endif

        // spurious completions while idle must not underflow the outstanding count
        repeat (3) pulse_done();
        reg_write(12'h008, 32'd820);
        reg_write(12'h00C, 32'h1000_0000);
        reg_write(12'h004, 32'h1);
        watch(10, nc, nfd);
        chk("spur ncmd", 32'(nc), 32'd1);
        chk("spur no early done", 32'(nfd), 32'd0);
        chk("spur busy", 32'(o_busy), 32'd1);
        pulse_done();
        watch(5, nc, nfd);
        chk("spur frame_done", 32'(nfd), 32'd1);
        frames++;

        // outstanding limit, ready stall, transfer+done in one cycle
        reg_write(12'h008, 32'd20480);
        reg_write(12'h004, 32'h1);
        watch(15, nc, nfd);
        chk("stall first burst", 32'(nc), 32'd2);
        chk("stall valid low", 32'(o_dma_cmd_valid), 32'd0);
        pulse_done();
        watch(10, nc, nfd);
        chk("stall release1", 32'(nc), 32'd1);
        pulse_done();
        watch(10, nc, nfd);
        chk("stall release2", 32'(nc), 32'd1);
        i_dma_cmd_ready = 1'b0;
        pulse_done();
        for (int i = 0; i < 5; i++) begin
            chk("hold valid", 32'(o_dma_cmd_valid), 32'd1);
            chk_cmd("hold data", o_dma_cmd_data, exp_cmd(32'h1000_4000, 23'd4096, 4'd4));
            tick();
        end
        i_dma_cmd_ready = 1'b1;
        i_dma_xfer_done = 1'b1;
        tick();
        i_dma_xfer_done = 1'b0;
        i_dma_cmd_ready = 1'b0;
        chk("xd valid low", 32'(o_dma_cmd_valid), 32'd0);
        watch(5, nc, nfd);
        chk("xd no early done", 32'(nfd), 32'd0);
        chk("xd busy", 32'(o_busy), 32'd1);
        pulse_done();
        watch(5, nc, nfd);
        chk("xd frame_done", 32'(nfd), 32'd1);
        frames++;

        // abort after second of four commands, start-while-busy ignored
        i_dma_cmd_ready = 1'b1;
        reg_write(12'h008, 32'd16384);
        reg_write(12'h004, 32'h1);
        watch(10, nc, nfd);
        chk("abort first burst", 32'(nc), 32'd2);
        reg_write(12'h008, 32'd100);
        reg_write(12'h004, 32'h1);
        chk("busy start ignored", 32'(o_send_start), 32'd0);
        chk("busy frame_len kept", 32'(o_frame_len), 32'd16384);
        reg_write(12'h004, 32'h2);
        pulse_done();
        watch(5, nc, nfd);
        chk("abort no 3rd cmd", 32'(nc), 32'd0);
        chk("abort no early done", 32'(nfd), 32'd0);
        pulse_done();
        watch(5, nc, nfd);
        chk("abort frame_done", 32'(nfd), 32'd1);
        chk("abort still no cmd", 32'(nc), 32'd0);
        frames++;
        reg_read(12'h014, rd);
        chk("abort status", rd, {16'(frames), 16'h0008});

        // soft reset mid-frame
        reg_write(12'h008, 32'd20480);
        reg_write(12'h004, 32'h1);
        watch(6, nc, nfd);
        chk("srst pre burst", 32'(nc), 32'd2);
        i_soft_rst = 1'b1;
        tick();
        i_soft_rst = 1'b0;
        chk("srst busy", 32'(o_busy), 32'd0);
        chk("srst valid", 32'(o_dma_cmd_valid), 32'd0);
        chk("srst frame_len", 32'(o_frame_len), 32'd0);
        reg_read(12'h014, rd);
        chk("srst status", rd, 32'h0);
        reg_read(12'h008, rd);
        chk("srst len", rd, 32'h0);
        run_frame("post_srst", 23'd820, 32'h1000_0000, 1, 23'd820);
        reg_read(12'h014, rd);
        chk("post_srst status", rd, 32'h0001_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
